mem_copy_engine: RTL and testbench

Block-copy initiator that drives the single-port byte data memory (`dat_mem`) through its address, write-data, write-enable and read-data pins. It sits beside the processor core and moves `len` bytes from `src` to `dst` on a `start` pulse, using read-then-write cycles against the memory's combinational read and clocked write. A compile-time fill mode writes a constant byte instead of copying.

---
 rtl/mem_copy_pkg.sv | 14 +
 rtl/mem_copy_engine.sv | 188 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the block-copy engine.
package mem_copy_pkg;

  localparam int MC_AW = 8;
  localparam int MC_DW = 8;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-serial block copy (read-then-write) against a single-port data memory.
// Optional constant-fill mode is compiled in with MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = MC_AW,
  parameter int DW = MC_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] ONE_C  = AW'(1);
  localparam logic [AW-1:0] ZERO_C = AW'(0);

  mc_state_t     state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          fill_active_s;
  logic [DW-1:0] fill_byte_s;

`ifdef MEM_COPY_FILL_EN
  logic          fill_q, fill_d;
  logic [DW-1:0] fval_q, fval_d;

  // Fill request and byte are captured together with the pointers on accept
  always_comb begin
    fill_d = fill_q;
    fval_d = fval_q;
    if (state_q == MC_IDLE && start) begin
      fill_d = fill;
      fval_d = fill_val;
    end else begin
      fill_d = fill_q;
      fval_d = fval_q;
    end
  end

  // Fill configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q <= 1'b0;
      fval_q <= {DW{1'b0}};
    end else begin
      fill_q <= fill_d;
      fval_q <= fval_d;
    end
  end

  assign fill_active_s = fill_d;
  assign fill_byte_s   = fval_d;
`else
  logic unused_fill_s;
  assign unused_fill_s = ^{fill, fill_val};
  assign fill_active_s = 1'b0;
  assign fill_byte_s   = {DW{1'b0}};
`endif

  // Next-state, pointer, count and hold-register logic
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      MC_IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          cnt_d = len;
          if (len == ZERO_C) begin
            state_d = MC_DONE;
          end else if (fill_active_s) begin
            state_d = MC_WRITE;
          end else begin
            state_d = MC_READ;
          end
        end else begin
          state_d = MC_IDLE;
        end
      end
      MC_READ: begin
        hold_d  = mem_rdata;
        state_d = MC_WRITE;
      end
      MC_WRITE: begin
        src_d = src_q + ONE_C;
        dst_d = dst_q + ONE_C;
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = MC_DONE;
        end else if (fill_active_s) begin
          state_d = MC_WRITE;
        end else begin
          state_d = MC_READ;
        end
      end
      MC_DONE: begin
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // without adding a cycle of latency to the memory pins.
  always_comb begin
    busy_d  = (state_d != MC_IDLE);
    done_d  = (state_d == MC_DONE);
    wr_en_d = (state_d == MC_WRITE);
    wdata_d = hold_d;
    addr_d  = ZERO_C;
    case (state_d)
      MC_READ: begin
        addr_d = src_d;
      end
      MC_WRITE: begin
        addr_d = dst_d;
        if (fill_active_s) begin
          wdata_d = fill_byte_s;
        end else begin
          wdata_d = hold_d;
        end
      end
      default: begin
        addr_d = ZERO_C;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      src_q   <= ZERO_C;
      dst_q   <= ZERO_C;
      cnt_q   <= ZERO_C;
      hold_q  <= {DW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= ZERO_C;
      wdata_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: mem_copy_engine wired to a behavioural dat_mem, checked
// each cycle against a forward-copy reference model.
module tb_mem_copy_engine;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef MEM_COPY_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          fill = 1'b0;
  logic [AW-1:0] src = 8'h00, dst = 8'h00, len = 8'h00;
  logic [DW-1:0] fill_val = 8'h00;
  logic          busy, done, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pre_wr = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_wr[$];

  int ecnt = 0;
  int k_start = -100;
  int busy_end = -100;
  int done_cyc = -100;
  int done_seen = -1;
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .fill(fill), .fill_val(fill_val), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // dat_mem: combinational read, clocked write
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pre_wr) mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecnt + 1);
    end
  endtask

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin : cmp
    int   c;
    logic eb;
    c = ecnt + 1;
    if (chk_en) begin
      eb = (c > k_start) && (c <= busy_end);
      check("busy", busy, eb);
      check("done", done, c == done_cyc);
      if (exp_wr.size() > 0 && exp_wr[0].cyc == c) begin
        check("wr_en", mem_wr_en, 1);
        check("wr_addr", mem_addr, exp_wr[0].addr);
        check("wr_data", mem_wdata, exp_wr[0].data);
        ref_mem[exp_wr[0].addr] = exp_wr[0].data;
        void'(exp_wr.pop_front());
      end else begin
        check("wr_en_idle", mem_wr_en, 0);
      end
      if (!eb) check("idle_addr", mem_addr, 0);
      if (done === 1'b1) done_seen = c;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_wr = 1'b1; pre_addr = a; pre_data = d; ref_mem[a] = d;
    @(negedge clk);
    pre_wr = 1'b0;
  endtask

  // Issues a start and builds the expected write stream from the forward-copy rule
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit f, input logic [7:0] fv);
    logic [7:0] sh [256];
    bit         is_fill;
    logic [7:0] a, v;
    int         k;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l; fill = f; fill_val = fv;
    k = ecnt + 1;
    is_fill = f && FILL_EN;
    sh = ref_mem;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 8'(i);
      v = is_fill ? fv : sh[8'(s + 8'(i))];
      sh[a] = v;
      exp_wr.push_back('{cyc: (is_fill ? k + 1 + i : k + 2 + 2 * i), addr: a, data: v});
    end
    done_cyc  = k + ((l == 8'd0) ? 1 : (is_fill ? int'(l) + 1 : 2 * int'(l) + 1));
    busy_end  = done_cyc;
    k_start   = k;
    done_seen = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish();
    int n;
    n = busy_end - (ecnt + 1) + 2;
    if (n < 1) n = 1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held while the memory is cleared
    @(negedge clk);
    pre_wr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i); pre_data = 8'h00; ref_mem[i] = 8'h00;
      @(negedge clk);
    end
    pre_wr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // basic copy, plus a start pulse while busy that must be ignored
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    do_start(8'h10, 8'h40, 8'd4, 1'b0, 8'h00);
    @(negedge clk);
    start = 1'b1; src = 8'h10; dst = 8'hA0; len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_finish();
    check("copy_40", mem[8'h40], 8'hA1);
    check("copy_41", mem[8'h41], 8'hB2);
    check("copy_42", mem[8'h42], 8'hC3);
    check("copy_43", mem[8'h43], 8'hD4);
    check("copy_done_cyc", done_seen - k_start, 9);
    check("busy_ignored_A0", mem[8'hA0], 8'h00);

    // zero length
    do_start(8'h10, 8'h50, 8'd0, 1'b0, 8'h00);
    wait_finish();
    check("len0_done_cyc", done_seen - k_start, 1);
    check("len0_mem50", mem[8'h50], 8'h00);

    // pointer wrap
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33); preload(8'h01, 8'h44);
    do_start(8'hFE, 8'h20, 8'd4, 1'b0, 8'h00);
    wait_finish();
    check("wrap_20", mem[8'h20], 8'h11);
    check("wrap_21", mem[8'h21], 8'h22);
    check("wrap_22", mem[8'h22], 8'h33);
    check("wrap_23", mem[8'h23], 8'h44);

    // overlapping forward copy smears the first byte
    preload(8'h00, 8'h01); preload(8'h01, 8'h02); preload(8'h02, 8'h03); preload(8'h03, 8'h04);
    do_start(8'h00, 8'h01, 8'd3, 1'b0, 8'h00);
    wait_finish();
    check("ovl_00", mem[8'h00], 8'h01);
    check("ovl_01", mem[8'h01], 8'h01);
    check("ovl_02", mem[8'h02], 8'h01);
    check("ovl_03", mem[8'h03], 8'h01);

    // reset in cycle k+3 aborts after one byte
    preload(8'h60, 8'h61); preload(8'h61, 8'h62); preload(8'h62, 8'h63); preload(8'h63, 8'h64);
    do_start(8'h60, 8'h70, 8'd4, 1'b0, 8'h00);
    @(negedge clk);
    start = 1'b1; src = 8'h10; dst = 8'h90; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    busy_end = ecnt + 1;
    done_cyc = -100;
    while (exp_wr.size() > 0 && exp_wr[$].cyc > busy_end) void'(exp_wr.pop_back());
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wr_en", mem_wr_en, 0);
    repeat (4) @(negedge clk);
    check("abort_70", mem[8'h70], 8'h61);
    check("abort_71", mem[8'h71], 8'h00);
    check("abort_no_done", done_seen, -1);
    check("abort_90", mem[8'h90], 8'h00);

    // fill request (copy when the feature is compiled out)
    do_start(8'h10, 8'h80, 8'd3, 1'b1, 8'h5A);
    wait_finish();
`ifdef MEM_COPY_FILL_EN
    check("fill_80", mem[8'h80], 8'h5A);
    check("fill_81", mem[8'h81], 8'h5A);
    check("fill_82", mem[8'h82], 8'h5A);
    check("fill_done_cyc", done_seen - k_start, 4);
`else
    check("nofill_80", mem[8'h80], 8'hA1);
    check("nofill_81", mem[8'h81], 8'hB2);
    check("nofill_82", mem[8'h82], 8'hC3);
    check("nofill_done_cyc", done_seen - k_start, 7);
`endif
    check("pending_writes", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
